// File: rtl/fastram_pkg.sv
// Shared types and constants for the fast-RAM CPU bus front end.
package fastram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    ACCESS  = 3'd2,
    ACK     = 3'd3,
    ERROR   = 3'd4,
    RELEASE = 3'd5,
    FOREIGN = 3'd6
  } state_e;

  localparam logic [2:0] FC_INTACK  = 3'b111;
  localparam logic [7:0] WIN_LO_DEF = 8'h40;
  localparam logic [7:0] WIN_HI_DEF = 8'hBF;

  function automatic logic in_window(input logic [7:0] a_hi,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (a_hi >= lo) && (a_hi <= hi);
  endfunction

endpackage

// File: rtl/fastram_bus_ctrl_if.sv
// CPU-side and SDRAM-controller-side signals of the fast-RAM bus front end.
interface fastram_bus_ctrl_if;
  logic        CPU_AS;
  logic        CPU_RW;
  logic [2:0]  CPU_FC;
  logic [22:0] CPU_A;
  logic        SD_READY;
  logic        SD_VALID;
  logic        SD_AS;
  logic        DTACK;
  logic        BERR;
  logic        OE_N;
  logic        DIR;
  logic        HIT;

  modport slave (
    input  CPU_AS, CPU_RW, CPU_FC, CPU_A, SD_READY, SD_VALID,
    output SD_AS, DTACK, BERR, OE_N, DIR, HIT
  );

  modport master (
    output CPU_AS, CPU_RW, CPU_FC, CPU_A, SD_READY, SD_VALID,
    input  SD_AS, DTACK, BERR, OE_N, DIR, HIT
  );
endinterface

// File: rtl/fastram_bus_ctrl_bus_timeout.sv
// Clear/enable saturating cycle counter with an expired flag.
// Only built when FASTRAM_BERR_EN is defined.
`ifdef FASTRAM_BERR_EN
module bus_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int             CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule
`endif

// File: rtl/fastram_bus_ctrl.sv
// 68000 bus front end for the fast-RAM SDRAM controller: decode, strobe gating, DTACK.
// Optional macro FASTRAM_BERR_EN adds the ACCESS timeout and the bus-error path.
module fastram_bus_ctrl
  import fastram_pkg::*;
#(
  parameter logic [7:0] WIN_LO  = WIN_LO_DEF,
  parameter logic [7:0] WIN_HI  = WIN_HI_DEF,
  parameter int         TIMEOUT = 64
) (
  input logic               CLK,
  input logic               RST,
  fastram_bus_ctrl_if.slave bus
);

  logic       r_as_p0, r_as_p1, w_as_s;
  state_e     r_state, w_state_nxt;
  logic       r_rw;
  logic [2:0] r_fc;
  logic [7:0] r_a_hi;
  logic       w_hit, w_tmo, w_drive;
  logic       r_sd_as, r_dtack, r_oe_n, r_dir, r_hit;
  logic       w_unused_a;

  assign w_as_s     = r_as_p1;
  assign w_unused_a = ^bus.CPU_A[14:0];

  // Cycle attributes captured on the edge AS_S is first seen low in IDLE
  always_ff @(posedge CLK) begin
    if ((r_state == IDLE) && !w_as_s) begin
      r_rw   <= bus.CPU_RW;
      r_fc   <= bus.CPU_FC;
      r_a_hi <= bus.CPU_A[22:15];
    end
  end

  assign w_hit = in_window(r_a_hi, WIN_LO, WIN_HI) && (r_fc != FC_INTACK);

`ifdef FASTRAM_BERR_EN
  logic w_tmo_clr, w_tmo_en, r_berr;

  assign w_tmo_clr = (r_state != ACCESS) && (w_state_nxt == ACCESS);
  assign w_tmo_en  = (r_state == ACCESS);

  bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_clr     (w_tmo_clr),
    .i_en      (w_tmo_en),
    .o_expired (w_tmo)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_berr <= 1'b1;
    else      r_berr <= (w_state_nxt != ERROR);
  end

  assign bus.BERR = r_berr;
`else
  localparam int unused_timeout = TIMEOUT;

  assign w_tmo    = 1'b0;
  assign bus.BERR = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_as_s) w_state_nxt = DECODE;
      DECODE: begin
        if (w_as_s)            w_state_nxt = IDLE;
        else if (!w_hit)       w_state_nxt = FOREIGN;
        else if (!bus.SD_READY) w_state_nxt = ACCESS;
      end
      // Abort beats VALID, VALID beats timeout
      ACCESS: begin
        if (w_as_s)            w_state_nxt = RELEASE;
        else if (!bus.SD_VALID) w_state_nxt = ACK;
        else if (w_tmo)        w_state_nxt = ERROR;
      end
      ACK:     if (w_as_s) w_state_nxt = RELEASE;
      ERROR:   if (w_as_s) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = IDLE;
      FOREIGN: if (w_as_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_drive = (w_state_nxt == ACCESS) || (w_state_nxt == ACK);

  // Outputs are registered from the next state so they change cleanly on the edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_as_p0 <= 1'b1;
      r_as_p1 <= 1'b1;
      r_state <= IDLE;
      r_sd_as <= 1'b1;
      r_dtack <= 1'b1;
      r_oe_n  <= 1'b1;
      r_dir   <= 1'b1;
      r_hit   <= 1'b0;
    end else begin
      r_as_p0 <= bus.CPU_AS;
      r_as_p1 <= r_as_p0;
      r_state <= w_state_nxt;
      r_sd_as <= !w_drive;
      r_oe_n  <= !w_drive;
      r_dtack <= (w_state_nxt != ACK);
      r_dir   <= w_drive ? r_rw : 1'b1;
      r_hit   <= w_drive || (w_state_nxt == ERROR);
    end
  end

  assign bus.SD_AS = r_sd_as;
  assign bus.DTACK = r_dtack;
  assign bus.OE_N  = r_oe_n;
  assign bus.DIR   = r_dir;
  assign bus.HIT   = r_hit;

endmodule

// File: tb/tb_fastram_bus_ctrl.sv
// Directed self-checking bench for fastram_bus_ctrl.
module tb_fastram_bus_ctrl;
  import fastram_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  fastram_bus_ctrl_if bus();

  fastram_bus_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_cycle(input logic [22:0] a, input logic [2:0] fc, input logic rw);
    @(negedge CLK);
    bus.CPU_A  = a;
    bus.CPU_FC = fc;
    bus.CPU_RW = rw;
    bus.CPU_AS = 1'b0;
  endtask

  task automatic end_cycle();
    @(negedge CLK);
    bus.CPU_AS   = 1'b1;
    bus.SD_VALID = 1'b1;
  endtask

  task automatic wait_sdas(output int n);
    bit seen;
    seen = 0;
    n    = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      n++;
      if (bus.SD_AS === 1'b0) seen = 1;
    end
  endtask

  typedef struct {
    logic [7:0] a_hi;
    logic [2:0] fc;
    logic       hit;
  } dec_vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int       n, bad;
    dec_vec_t vecs[5];

    bus.CPU_AS   = 1'b1;
    bus.CPU_RW   = 1'b1;
    bus.CPU_FC   = 3'b000;
    bus.CPU_A    = '0;
    bus.SD_READY = 1'b0;
    bus.SD_VALID = 1'b1;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_sd_as", bus.SD_AS, 1);
    chk("rst_dtack", bus.DTACK, 1);
    chk("rst_berr",  bus.BERR,  1);
    chk("rst_oe_n",  bus.OE_N,  1);
    chk("rst_dir",   bus.DIR,   1);
    chk("rst_hit",   bus.HIT,   0);
    chk("rst_state", dut.r_state, IDLE);
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // Read at 0x400000
    start_cycle(23'h200000, 3'b101, 1'b1);
    wait_sdas(n);
    chk("rd_sdas_lat", n, 4);
    chk("rd_hit",   bus.HIT,   1);
    chk("rd_oe_n",  bus.OE_N,  0);
    chk("rd_dir",   bus.DIR,   1);
    chk("rd_dtack_pre", bus.DTACK, 1);
    repeat (5) tick();
    chk("rd_dtack_wait", bus.DTACK, 1);
    @(negedge CLK);
    bus.SD_VALID = 1'b0;
    tick();
    chk("rd_dtack",  bus.DTACK, 0);
    chk("rd_ack_st", dut.r_state, ACK);
    chk("rd_ack_oe", bus.OE_N, 0);
    chk("rd_ack_as", bus.SD_AS, 0);
    end_cycle();
    tick();
    tick();
    chk("rd_dtack_hold", bus.DTACK, 0);
    tick();
    chk("rd_dtack_rel", bus.DTACK, 1);
    chk("rd_sdas_rel",  bus.SD_AS, 1);
    chk("rd_rel_st",    dut.r_state, RELEASE);
    chk("rd_rel_hit",   bus.HIT, 0);
    tick();
    chk("rd_idle_st",   dut.r_state, IDLE);
    chk("rd_idle_sdas", bus.SD_AS, 1);

    // ROM access at 0x00FC00 is foreign
    start_cycle(23'h007E00, 3'b110, 1'b1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.SD_AS !== 1'b1 || bus.DTACK !== 1'b1 || bus.OE_N !== 1'b1 || bus.HIT !== 1'b0) bad++;
    end
    chk("rom_quiet",  bad, 0);
    chk("rom_state",  dut.r_state, FOREIGN);
    end_cycle();
    repeat (3) tick();
    chk("rom_idle",   dut.r_state, IDLE);

    // Window edges and interrupt acknowledge
    vecs[0] = '{8'hBF, 3'b101, 1'b1};
    vecs[1] = '{8'hC0, 3'b101, 1'b0};
    vecs[2] = '{8'h3F, 3'b110, 1'b0};
    vecs[3] = '{8'h40, 3'b111, 1'b0};
    vecs[4] = '{8'h80, 3'b010, 1'b1};
    for (int v = 0; v < 5; v++) begin
      start_cycle({vecs[v].a_hi, 15'h0}, vecs[v].fc, 1'b1);
      repeat (4) tick();
      chk($sformatf("dec%0d_state", v), dut.r_state, vecs[v].hit ? ACCESS : FOREIGN);
      chk($sformatf("dec%0d_hit", v), bus.HIT, vecs[v].hit);
      end_cycle();
      repeat (4) tick();
      chk($sformatf("dec%0d_idle", v), dut.r_state, IDLE);
    end

    // Controller initialising: stall in DECODE, then a write
    @(negedge CLK);
    bus.SD_READY = 1'b1;
    start_cycle(23'h208000, 3'b001, 1'b0);
    repeat (3) tick();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.SD_AS !== 1'b1) bad++;
    end
    chk("init_sdas_held", bad, 0);
    chk("init_state", dut.r_state, DECODE);
    @(negedge CLK);
    bus.SD_READY = 1'b0;
    tick();
    chk("init_sdas_fall", bus.SD_AS, 0);
    chk("init_dir_wr",    bus.DIR, 0);
    @(negedge CLK);
    bus.SD_VALID = 1'b0;
    tick();
    chk("init_dtack", bus.DTACK, 0);
    end_cycle();
    repeat (3) tick();
    chk("init_dtack_rel", bus.DTACK, 1);
    tick();
    chk("init_idle", dut.r_state, IDLE);

`ifdef FASTRAM_BERR_EN
    // Stuck VALID raises bus error after 64 cycles in ACCESS
    start_cycle(23'h280000, 3'b101, 1'b1);
    wait_sdas(n);
    n   = 0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (bus.DTACK !== 1'b1) bad++;
      if (bus.BERR === 1'b0) break;
    end
    chk("tmo_cycles",  n, 64);
    chk("tmo_no_dtack", bad, 0);
    chk("tmo_state",   dut.r_state, ERROR);
    chk("tmo_sdas",    bus.SD_AS, 1);
    chk("tmo_oe_n",    bus.OE_N, 1);
    chk("tmo_hit",     bus.HIT, 1);
    end_cycle();
    tick();
    tick();
    chk("tmo_berr_hold", bus.BERR, 0);
    tick();
    chk("tmo_berr_rel",  bus.BERR, 1);
    chk("tmo_rel_state", dut.r_state, RELEASE);
    tick();

    // VALID on the expiry cycle wins over the timeout
    start_cycle(23'h280000, 3'b101, 1'b1);
    wait_sdas(n);
    repeat (63) tick();
    @(negedge CLK);
    bus.SD_VALID = 1'b0;
    tick();
    chk("tmo_race_state", dut.r_state, ACK);
    chk("tmo_race_berr",  bus.BERR, 1);
    chk("tmo_race_dtack", bus.DTACK, 0);
    end_cycle();
    repeat (4) tick();
`else
    // Without the timeout, ACCESS waits indefinitely
    start_cycle(23'h280000, 3'b101, 1'b1);
    wait_sdas(n);
    repeat (100) tick();
    chk("wait_berr",  bus.BERR, 1);
    chk("wait_sdas",  bus.SD_AS, 0);
    chk("wait_state", dut.r_state, ACCESS);
    end_cycle();
    repeat (3) tick();
    chk("wait_rel",   dut.r_state, RELEASE);
    tick();
`endif

    // Abort in ACCESS on the same cycle VALID falls
    start_cycle(23'h300000, 3'b101, 1'b1);
    wait_sdas(n);
    tick();
    tick();
    @(negedge CLK);
    bus.CPU_AS = 1'b1;
    tick();
    tick();
    chk("abt_dtack_b", bus.DTACK, 1);
    @(negedge CLK);
    bus.SD_VALID = 1'b0;
    tick();
    chk("abt_state", dut.r_state, RELEASE);
    chk("abt_dtack", bus.DTACK, 1);
    chk("abt_sdas",  bus.SD_AS, 1);
    @(negedge CLK);
    bus.SD_VALID = 1'b1;
    tick();
    chk("abt_idle",  dut.r_state, IDLE);
    chk("abt_dtack_idle", bus.DTACK, 1);

    // Asynchronous reset while in ACK
    start_cycle(23'h200000, 3'b101, 1'b1);
    wait_sdas(n);
    @(negedge CLK);
    bus.SD_VALID = 1'b0;
    tick();
    chk("ar_pre_dtack", bus.DTACK, 0);
    #2;
    RST = 1'b0;
    #1;
    chk("ar_dtack", bus.DTACK, 1);
    chk("ar_sdas",  bus.SD_AS, 1);
    chk("ar_oe_n",  bus.OE_N, 1);
    chk("ar_state", dut.r_state, IDLE);
    bus.CPU_AS   = 1'b1;
    bus.SD_VALID = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    tick();
    tick();
    chk("ar_post_state", dut.r_state, IDLE);
    chk("ar_post_sdas",  bus.SD_AS, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
